ps2_keycode_rx: RTL and testbench
=================================

Name: ps2_keycode_rx

Overview:
- PS/2 keyboard receiver and scan-code decoder. Drives the 16-bit two-player keycode bus {key_p1, key_p2} directly from a PS/2 keyboard, so the player blocks can run without the NIOS/USB path.
- Decodes set-2 make/break sequences into HID usage codes, which are the values the player control vectors already compare against.
- Sits at top level. Its keycode output is muxed with the USB keycode before the key_p1/key_p2 split.

Parameters:
- FILTER_CYCLES, 8: consecutive clk cycles ps2_clk must hold a new level before it is accepted.
- TIMEOUT_CYCLES, 50000: cycles without a filtered ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock, CLOCK_50 domain.
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the keyboard, asynchronous.
- ps2_dat  in  1  raw PS/2 data from the keyboard, asynchronous.
- keycode  out  16  [15:8] player-1 held HID usage, [7:0] player-2 held HID usage; 0 means no key held.
- byte_strobe  out  1  one-cycle pulse; a valid byte is on scan_byte.
- scan_byte  out  8  last correctly received raw byte.
- rx_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Reset state (async): keycode=0, scan_byte=0, byte_strobe=0, rx_err=0, FSM=IDLE, brk=0, ext=0, all counters 0.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-flop synchronizer.
  - ps2_clk is then filtered: the filtered level changes only after FILTER_CYCLES identical consecutive samples.
  - fall is a one-cycle pulse on a filtered 1->0 transition.
- Frame FSM (advances only on fall; data is sampled on that cycle):
  - IDLE: dat=0 -> DATA with bitcnt=0. dat=1 -> stay in IDLE, no error.
  - DATA: shift LSB-first into sr; after the 8th bit -> PARITY.
  - PARITY: if ^{sr,dat} != 1 (odd parity fails), latch perr=1; -> STOP.
  - STOP: dat=1 and perr=0 -> byte accepted, IDLE. Otherwise rx_err pulses, byte discarded, IDLE.
- Timeout: a timer counts cycles in any state other than IDLE and clears on fall. Reaching TIMEOUT_CYCLES forces IDLE, pulses rx_err, and clears perr. The partial byte is dropped.
- Latency:
  - The clk cycle after the STOP-state fall: scan_byte is updated and byte_strobe=1.
  - The following cycle: keycode reflects the decoded byte.
- Decode (acts on each accepted byte):
  - 0xE0: set ext.
  - 0xF0: set brk.
  - Any other byte: look up the player/usage; then clear brk and ext.
  - ext=1: the code is consumed and ignored, including extended breaks.
- Player-1 map (set-2 scan -> HID usage): 1D->26 W, 1B->22 S, 1C->04 A, 23->07 D, 15->20 Q, 24->08 E, 16->30 1, 26->32 3.
- Player-2 map (set-2 scan -> HID usage): 43->12 I, 42->14 K, 3B->13 J, 4B->15 L, 3C->24 U, 44->18 O, 3E->37 8, 46->38 9.
- Make of a mapped key: the owning half of keycode <= usage. Last make wins, including typematic repeats of the same key (no change).
- Break of a mapped key: the owning half <= 0 only if it currently equals that usage. Otherwise keycode is unchanged.
- Unmapped codes: no keycode change.
- Player independence: player-1 and player-2 halves are independent; a P2 make never alters [15:8].
- Reset mid-frame: immediate return to reset state; the next frame is received normally.

Optional Feature:
- Macro: PS2_ERRCNT_EN.
- Defined:
  - Adds output err_count [7:0], a saturating count of rx_err pulses (stops at 255), cleared by reset.
  - Adds output last_err [1:0]: 0 parity, 1 start/stop, 2 timeout.
- Undefined: neither port nor the counter exists; all other behaviour is identical.

Decomposition:
- Package ps2_pkg holds:
  - the FSM enum (IDLE, DATA, PARITY, STOP);
  - localparams SC_EXT=8'hE0 and SC_BRK=8'hF0;
  - the 16 scan/usage constant pairs;
  - function scan2hid(input [7:0]) returning {valid, player, usage[7:0]}.
- Sub-module ps2_line_cond: synchronizer plus FILTER_CYCLES glitch filter and fall pulse. It is instantiated once for ps2_clk. ps2_dat uses only the synchronizer.

Test Plan:
- Make W: send frame 0x1D (parity 1) -> byte_strobe once, scan_byte=0x1D, keycode=16'h1A00 two cycles after the stop edge.
- Break W: with W held, send F0,1D -> keycode=16'h0000. Then send F0,1C (A, not held) -> keycode stays 16'h0000.
- Both players: send 1D then 43 -> keycode=16'h1A0C. Then send F0,43 -> keycode=16'h1A00.
- Parity error: send 0x1C with the parity bit inverted -> rx_err pulse, no byte_strobe, keycode unchanged. The next good frame 0x1C is accepted, giving keycode[15:8]=8'h04.
- Timeout and glitch:
  - Stop ps2_clk after 5 bits for more than 50000 cycles -> rx_err, FSM back to IDLE, and the next full 0x16 frame gives keycode[15:8]=8'h1E.
  - A 3-cycle ps2_clk low glitch produces no bit.
- Extended/reset: send E0,75 -> no change. Assert reset_n=0 mid-frame -> all outputs 0 at once.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 receiver FSM states, special scan codes and set-2 to HID key map
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Player 1: W S A D Q E 1 3
  localparam logic [7:0] SC_W  = 8'h1D, HID_W  = 8'h1A;
  localparam logic [7:0] SC_S  = 8'h1B, HID_S  = 8'h16;
  localparam logic [7:0] SC_A  = 8'h1C, HID_A  = 8'h04;
  localparam logic [7:0] SC_D  = 8'h23, HID_D  = 8'h07;
  localparam logic [7:0] SC_Q  = 8'h15, HID_Q  = 8'h14;
  localparam logic [7:0] SC_E  = 8'h24, HID_E  = 8'h08;
  localparam logic [7:0] SC_1  = 8'h16, HID_1  = 8'h1E;
  localparam logic [7:0] SC_3  = 8'h26, HID_3  = 8'h20;

  // Player 2: I K J L U O 8 9
  localparam logic [7:0] SC_I  = 8'h43, HID_I  = 8'h0C;
  localparam logic [7:0] SC_K  = 8'h42, HID_K  = 8'h0E;
  localparam logic [7:0] SC_J  = 8'h3B, HID_J  = 8'h0D;
  localparam logic [7:0] SC_L  = 8'h4B, HID_L  = 8'h0F;
  localparam logic [7:0] SC_U  = 8'h3C, HID_U  = 8'h18;
  localparam logic [7:0] SC_O  = 8'h44, HID_O  = 8'h12;
  localparam logic [7:0] SC_8  = 8'h3E, HID_8  = 8'h25;
  localparam logic [7:0] SC_9  = 8'h46, HID_9  = 8'h26;

  // Returns {valid, player (0 = P1, 1 = P2), usage[7:0]}
  function automatic logic [9:0] scan2hid(input logic [7:0] scan);
    logic [9:0] r;
    case (scan)
      SC_W:    r = {1'b1, 1'b0, HID_W};
      SC_S:    r = {1'b1, 1'b0, HID_S};
      SC_A:    r = {1'b1, 1'b0, HID_A};
      SC_D:    r = {1'b1, 1'b0, HID_D};
      SC_Q:    r = {1'b1, 1'b0, HID_Q};
      SC_E:    r = {1'b1, 1'b0, HID_E};
      SC_1:    r = {1'b1, 1'b0, HID_1};
      SC_3:    r = {1'b1, 1'b0, HID_3};
      SC_I:    r = {1'b1, 1'b1, HID_I};
      SC_K:    r = {1'b1, 1'b1, HID_K};
      SC_J:    r = {1'b1, 1'b1, HID_J};
      SC_L:    r = {1'b1, 1'b1, HID_L};
      SC_U:    r = {1'b1, 1'b1, HID_U};
      SC_O:    r = {1'b1, 1'b1, HID_O};
      SC_8:    r = {1'b1, 1'b1, HID_8};
      SC_9:    r = {1'b1, 1'b1, HID_9};
      default: r = 10'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_line_cond.sv
// rtl/ps2_line_cond.sv - PS/2 clock line synchronizer, glitch filter and falling-edge pulse
module ps2_line_cond #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic fall
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Idle PS/2 lines are high, so the conditioned level starts high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync[1];
          cnt   <= '0;
          fall  <= level;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// rtl/ps2_keycode_rx.sv - PS/2 set-2 receiver decoding make/break codes into the two-player HID keycode bus
// Optional error counter and last-error code when PS2_ERRCNT_EN is defined.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [15:0] keycode,
  output logic        byte_strobe,
  output logic [7:0]  scan_byte,
  output logic        rx_err
`ifdef PS2_ERRCNT_EN
  ,
  output logic [7:0]  err_count,
  output logic [1:0]  last_err
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic          fall;
  logic [1:0]    dat_sync;
  logic          dat_s;
  ps2_state_e    state;
  logic [2:0]    bitcnt;
  logic [7:0]    sr;
  logic          perr;
  logic [TW-1:0] timer;
  logic          stop_err;
  logic          tmo;
  logic          brk;
  logic          ext;
  logic [9:0]    hid;

  ps2_line_cond #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_cond (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (ps2_clk),
    .fall   (fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dat_sync <= 2'b11;
    else          dat_sync <= {dat_sync[0], ps2_dat};
  end
  assign dat_s = dat_sync[1];

  always_comb begin
    stop_err = fall && (state == STOP) && !(dat_s && !perr);
    tmo      = !fall && (state != IDLE) && (timer == TMO_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bitcnt      <= 3'd0;
      sr          <= 8'd0;
      perr        <= 1'b0;
      timer       <= '0;
      scan_byte   <= 8'd0;
      byte_strobe <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      rx_err      <= stop_err | tmo;
      if (fall) begin
        timer <= '0;
        case (state)
          IDLE: begin
            if (!dat_s) begin
              state  <= DATA;
              bitcnt <= 3'd0;
              perr   <= 1'b0;
            end
          end
          DATA: begin
            sr     <= {dat_s, sr[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            perr  <= ~(^{sr, dat_s});
            state <= STOP;
          end
          STOP: begin
            if (!stop_err) begin
              scan_byte   <= sr;
              byte_strobe <= 1'b1;
            end
            perr  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (tmo) begin
        state <= IDLE;
        timer <= '0;
        perr  <= 1'b0;
      end else if (state != IDLE) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= '0;
      end
    end
  end

  assign hid = scan2hid(scan_byte);

  // Prefix bytes only arm flags; the terminal byte applies them and clears both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keycode <= 16'd0;
      brk     <= 1'b0;
      ext     <= 1'b0;
    end else if (byte_strobe) begin
      if (scan_byte == SC_EXT) begin
        ext <= 1'b1;
      end else if (scan_byte == SC_BRK) begin
        brk <= 1'b1;
      end else begin
        if (!ext && hid[9]) begin
          if (hid[8]) begin
            if (!brk)                       keycode[7:0] <= hid[7:0];
            else if (keycode[7:0] == hid[7:0]) keycode[7:0] <= 8'd0;
          end else begin
            if (!brk)                        keycode[15:8] <= hid[7:0];
            else if (keycode[15:8] == hid[7:0]) keycode[15:8] <= 8'd0;
          end
        end
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

`ifdef PS2_ERRCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= 8'd0;
      last_err  <= 2'd0;
    end else if (stop_err || tmo) begin
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      last_err <= tmo ? 2'd2 : (perr ? 2'd0 : 2'd1);
    end
  end
`endif

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb/tb_ps2_keycode_rx.sv - scoreboard bench for ps2_keycode_rx (PS2_ERRCNT_EN adds error-count checks)
module tb_ps2_keycode_rx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [15:0] keycode;
  logic        byte_strobe;
  logic [7:0]  scan_byte;
  logic        rx_err;
`ifdef PS2_ERRCNT_EN
  logic [7:0]  err_count;
  logic [1:0]  last_err;
`endif

  ps2_keycode_rx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .keycode    (keycode),
    .byte_strobe(byte_strobe),
    .scan_byte  (scan_byte),
    .rx_err     (rx_err)
`ifdef PS2_ERRCNT_EN
    ,
    .err_count  (err_count),
    .last_err   (last_err)
`endif
  );

  always #5 clk = ~clk;

  localparam int H = 20;

  typedef struct {
    bit          is_err;
    logic [7:0]  b;
    logic [15:0] kc;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          pend_kc = 1'b0;
  logic [15:0] pend_exp;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a byte or an error.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      if (pend_kc) begin
        check16("keycode_after_byte", keycode, pend_exp);
        pend_kc = 1'b0;
      end
      if (byte_strobe === 1'b1 || rx_err === 1'b1) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got strobe=%b err=%b byte=%h, expected no event",
                   byte_strobe, rx_err, scan_byte);
        end else begin
          e = q.pop_front();
          check16("event_kind", {15'd0, rx_err}, {15'd0, e.is_err});
          if (e.is_err) begin
            check16("keycode_on_err", keycode, e.kc);
          end else begin
            check16("scan_byte", {8'd0, scan_byte}, {8'd0, e.b});
            pend_exp = e.kc;
            pend_kc  = 1'b1;
          end
        end
      end
    end
  end

  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_dat = 1'b1;
    repeat (H) @(posedge clk);
  endtask

  task automatic send_good(input logic [7:0] b, input logic [15:0] kc);
    q.push_back('{1'b0, b, kc});
    send_bits(b, 1'b0, 11);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || pend_kc) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q.size() != 0 || pend_kc) begin
      miscompares++;
      $display("FAIL drain_%s: got %0d events outstanding, expected 0", name, q.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (4) @(negedge clk);
    check16("rst_keycode", keycode, 16'h0000);
    check16("rst_scan_byte", {8'd0, scan_byte}, 16'h0000);
    check16("rst_flags", {14'd0, byte_strobe, rx_err}, 16'h0000);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);

    // Make / break of W, break of a key that is not held
    send_good(8'h1D, 16'h1A00);
    send_good(8'hF0, 16'h1A00);
    send_good(8'h1D, 16'h0000);
    send_good(8'hF0, 16'h0000);
    send_good(8'h1C, 16'h0000);
    // Both players
    send_good(8'h1D, 16'h1A00);
    send_good(8'h43, 16'h1A0C);
    send_good(8'hF0, 16'h1A0C);
    send_good(8'h43, 16'h1A00);
    drain("basic");

    // Parity error then good frame
    q.push_back('{1'b1, 8'h1C, 16'h1A00});
    send_bits(8'h1C, 1'b1, 11);
    send_good(8'h1C, 16'h0400);
    drain("parity");

    // Timeout: clock stops after 5 bits
    q.push_back('{1'b1, 8'h00, 16'h0400});
    send_bits(8'h16, 1'b0, 5);
    repeat (50100) @(posedge clk);
    drain("timeout");
`ifdef PS2_ERRCNT_EN
    check16("last_err_timeout", {14'd0, last_err}, 16'd2);
    check16("err_count", {8'd0, err_count}, 16'd2);
`endif
    send_good(8'h16, 16'h1E00);
    drain("after_timeout");

    // 3-cycle clock glitch with data low must not start a frame
    ps2_dat = 1'b0;
    @(posedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(posedge clk);
    ps2_dat = 1'b1;
    repeat (20) @(posedge clk);
    send_good(8'h24, 16'h0800);

    // P2 independence, unmapped code, typematic repeat, extended codes
    send_good(8'h42, 16'h080E);
    send_good(8'h5A, 16'h080E);
    send_good(8'h42, 16'h080E);
    send_good(8'hE0, 16'h080E);
    send_good(8'h75, 16'h080E);
    send_good(8'hE0, 16'h080E);
    send_good(8'hF0, 16'h080E);
    send_good(8'h42, 16'h080E);
    drain("ext");

    // Reset mid-frame
    send_bits(8'h1D, 1'b0, 4);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check16("midrst_keycode", keycode, 16'h0000);
    check16("midrst_scan_byte", {8'd0, scan_byte}, 16'h0000);
    check16("midrst_flags", {14'd0, byte_strobe, rx_err}, 16'h0000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    send_good(8'h1D, 16'h1A00);
    drain("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
